bist_mnc: RTL and testbench

//  On-chip stimulus/response stage wrapped around circuito_compuertas (4-in ABCD, 2-out F1/F2).

---
 rtl/bist_mnc_pkg.sv | 15 +
 rtl/bist_mnc_golden_rom.sv | 15 +
 rtl/bist_mnc.sv | 135 +++++++++++++
 tb/tb_bist_mnc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_mnc_pkg.sv
// Shared types and constants for the bist_mnc self-test stage.
package bist_mnc_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam logic [31:0] MNC_GOLDEN = 32'hEEEE_77EC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bist_mnc_golden_rom.sv
// Golden {F1,F2} lookup: code i reads table bits [2i+1:2i].
module bist_mnc_golden_rom
  import bist_mnc_pkg::*;
#(
  parameter logic [31:0] TABLE = MNC_GOLDEN
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [1:0]       o_exp
);

  always_comb begin
    o_exp = TABLE[{i_idx, 1'b0} +: 2];
  end

endmodule

// File: rtl/bist_mnc.sv
// Exhaustive stimulus/response BIST around circuito_compuertas.
// Define BIST_MNC_STOP_ON_ERR_EN to end the run at the first mismatch.
module bist_mnc
  import bist_mnc_pkg::*;
#(
  parameter int unsigned N_VEC     = 16,
  parameter int unsigned SETTLE    = 2,
  parameter logic [31:0] EXP_TABLE = MNC_GOLDEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] abcd,
  input  logic             f1,
  input  logic             f2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int unsigned SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  state_e           r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [SET_W-1:0] r_settle, w_settle;
  logic [ERR_W-1:0] r_err, w_err;
  logic             r_fev, w_fev;
  logic [IDX_W-1:0] r_fei, w_fei;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic [1:0]       w_exp;
  logic             w_mis;
  logic             w_stop;

  bist_mnc_golden_rom #(.TABLE(EXP_TABLE)) u_rom (
    .i_idx (r_idx),
    .o_exp (w_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_settle <= '0;
      r_err    <= '0;
      r_fev    <= 1'b0;
      r_fei    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_settle <= w_settle;
      r_err    <= w_err;
      r_fev    <= w_fev;
      r_fei    <= w_fei;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_pass   <= w_pass;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_settle = r_settle;
    w_err    = r_err;
    w_fev    = r_fev;
    w_fei    = r_fei;
    w_busy   = r_busy;
    w_done   = r_done;
    w_pass   = r_pass;
    w_mis    = ({f1, f2} != w_exp);
    w_stop   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state  = ST_APPLY;
          w_idx    = '0;
          w_settle = '0;
          w_err    = '0;
          w_fev    = 1'b0;
          w_fei    = '0;
          w_busy   = 1'b1;
          w_done   = 1'b0;
          w_pass   = 1'b0;
        end
      end
      ST_APPLY: begin
        w_settle = r_settle + SET_W'(1);
        if (r_settle == SET_W'(SETTLE - 1)) w_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_mis) begin
          w_err = r_err + ERR_W'(1);
          if (!r_fev) begin
            w_fev = 1'b1;
            w_fei = r_idx;
          end
`ifdef BIST_MNC_STOP_ON_ERR_EN
          w_stop = 1'b1;
`else
          w_stop = 1'b0;
`endif
        end
        if (w_stop || (r_idx == IDX_W'(N_VEC - 1))) begin
          w_state = ST_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = (w_err == '0);
        end else begin
          w_state  = ST_APPLY;
          w_idx    = r_idx + IDX_W'(1);
          w_settle = '0;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // abcd is the registered vector index; it therefore holds the last code in DONE.
  assign abcd            = r_idx;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_cnt         = r_err;
  assign first_err_valid = r_fev;
  assign first_err_idx   = r_fei;

endmodule

// File: tb/tb_bist_mnc.sv
// Randomized bench for bist_mnc with a vector-level reference model of a run.
module tb_bist_mnc;

`ifdef BIST_MNC_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam int unsigned NV  = 16;
  localparam int unsigned PER = 3;
  localparam logic [31:0] GOLD = 32'hEEEE_77EC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       f1, f2;
  logic [3:0] abcd;
  logic       busy, done, pass, first_err_valid;
  logic [4:0] err_cnt;
  logic [3:0] first_err_idx;

  logic [1:0] fault     [NV];
  logic [1:0] run_fault [NV];

  int n_vec = 0;
  int n_fail = 0;

  int m_state = 0;  // 0 idle, 1 running, 2 done
  int m_k = 0;
  int m_endk = 0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  bist_mnc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abcd            (abcd),
    .f1              (f1),
    .f2              (f2),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx)
  );

  function automatic logic [1:0] gold(input int unsigned c);
    logic [31:0] t;
    t = GOLD;
    return t[2*c +: 2];
  endfunction

  // Circuit under test: golden behaviour with an injectable per-code xor fault.
  always_comb begin
    {f1, f2} = gold(32'(abcd)) ^ fault[abcd];
  end

  function automatic int first_bad(input logic [1:0] fl [NV]);
    for (int i = 0; i < NV; i++) if (fl[i] != 2'b00) return i;
    return NV;
  endfunction

  function automatic int bad_before(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (run_fault[i] != 2'b00) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    int nk;
    int fb;
    if (!rst_n) begin
      m_state <= 0;
      m_valid <= 1'b1;
    end else if (m_state != 1 && start) begin
      m_state   <= 1;
      m_k       <= 0;
      run_fault <= fault;
      fb = first_bad(fault);
      m_endk <= (STOP && fb < NV) ? PER * (fb + 1) : PER * NV;
    end else if (m_state == 1) begin
      nk = m_k + 1;
      m_k <= nk;
      if (nk == m_endk) m_state <= 2;
    end
  end

  always @(negedge clk) begin
    logic [16:0] e, a;
    int nchk, ne, fb;
    if (m_valid) begin
      e = '0;
      fb = first_bad(run_fault);
      if (m_state == 1) begin
        nchk = m_k / PER;
        ne = bad_before(nchk);
        e = {1'b1, 1'b0, 1'b0, 4'(nchk), 5'(ne), ne > 0, (ne > 0) ? 4'(fb) : 4'd0};
      end else if (m_state == 2) begin
        nchk = m_endk / PER;
        ne = bad_before(nchk);
        e = {1'b0, 1'b1, ne == 0, 4'(nchk - 1), 5'(ne), ne > 0, (ne > 0) ? 4'(fb) : 4'd0};
      end
      a = {busy, done, pass, abcd, err_cnt, first_err_valid, first_err_idx};
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got busy/done/pass/abcd/err/fev/fei=%b/%b/%b/%0d/%0d/%b/%0d expected %b/%b/%b/%0d/%0d/%b/%0d",
                 $time, a[16], a[15], a[14], a[13:10], a[9:5], a[4], a[3:0],
                 e[16], e[15], e[14], e[13:10], e[9:5], e[4], e[3:0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_fault();
    for (int i = 0; i < NV; i++) fault[i] = 2'b00;
  endtask

  task automatic run(input bit hold, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    logic [1:0] g;
    clear_fault();
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_abcd", int'(abcd), 0);

    // Clean circuit
    run(1'b0, cyc);
    chk("clean_cycles", cyc, 48);
    chk("clean_pass", int'(pass), 1);
    chk("clean_err", int'(err_cnt), 0);
    chk("clean_fev", int'(first_err_valid), 0);
    chk("clean_abcd", int'(abcd), 15);

    // F1 stuck-at-0
    for (int i = 0; i < NV; i++) begin
      g = gold(i);
      fault[i] = {g[1], 1'b0};
    end
    run(1'b0, cyc);
    chk("f1sa0_cycles", cyc, STOP ? 6 : 48);
    chk("f1sa0_err", int'(err_cnt), STOP ? 1 : 13);
    chk("f1sa0_fei", int'(first_err_idx), 1);
    chk("f1sa0_pass", int'(pass), 0);
    chk("f1sa0_abcd", int'(abcd), STOP ? 1 : 15);

    // F2 forced to 1 at code 2 only
    clear_fault();
    fault[2] = 2'b01;
    run(1'b0, cyc);
    chk("f2c2_err", int'(err_cnt), 1);
    chk("f2c2_fei", int'(first_err_idx), 2);
    chk("f2c2_fev", int'(first_err_valid), 1);

    // Reset mid-run at code 7
    clear_fault();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (abcd != 4'd7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_abcd7", int'(abcd), 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_abcd", int'(abcd), 0);
    chk("midrst_err", int'(err_cnt), 0);

    // Start held through the run, then restart from DONE
    run(1'b1, cyc);
    chk("hold_cycles", cyc, 48);
    fault[5] = 2'b11;
    run(1'b0, cyc);
    chk("restart_cycles", cyc, STOP ? 18 : 48);
    chk("restart_err", int'(err_cnt), 1);
    chk("restart_fei", int'(first_err_idx), 5);

    // Random fault patterns, gaps and occasional aborts
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NV; i++)
        fault[i] = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      repeat ($urandom_range(3)) @(negedge clk);
      if ($urandom_range(4) == 0) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(40)) @(negedge clk);
        do_reset();
      end else begin
        run(1'($urandom_range(1)), cyc);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
